serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Serial frame receiver: the receive end of the team's idle-high, one-bit-per-clock serial shift link. It samples `sdin` every clock, detects a start bit, deserializes `WIDTH` data bits LSB-first, checks the stop bit (and optionally parity), and presents the word on a single-entry valid/ready output register. It sits after the serial shift chain and feeds parallel consumers.

## Interface
- `WIDTH`, default 8: data bits per frame; legal values 2 to 32.
- `clk`  in  1  clock; all logic rises on posedge.
- `reset`  in  1  reset, synchronous, active-high.
- `sdin`  in  1  serial line; idle level 1; one bit per clock.
- `dout`  out  WIDTH  received word; valid while `dout_valid`=1.
- `dout_valid`  out  1  output register holds an unread word.
- `dout_ready`  in  1  consumer accepts `dout` on a cycle where `dout_valid`=1 and `dout_ready`=1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
- `overrun`  out  1  one-cycle pulse: good frame dropped because the output register was full.

## Operation
- States: IDLE, DATA, PARITY (only with `SERIAL_FRAME_RX_PARITY_EN`), STOP, BREAK.
- IDLE: if `sdin`=0, treat it as the start bit, clear the bit counter, and go to DATA. Otherwise stay in IDLE.
- DATA: shift `sdin` into bit position `cnt` (LSB first) and increment `cnt`. After WIDTH bits, go to PARITY if it is enabled, otherwise go to STOP.
- PARITY: compare `sdin` with the XOR of the data bits (even parity). Record any mismatch. Go to STOP.
- STOP, with `sdin`=1:
  - If a parity mismatch was recorded: pulse `parity_err` and discard the frame.
  - Otherwise, if the output register is empty, or is being drained this cycle: load `dout` and hold `dout_valid`=1.
  - Otherwise: pulse `overrun`, keep the old word, and drop the new one.
  - In all three cases, go to IDLE.
- STOP, with `sdin`=0: pulse `frame_err`, discard the frame (a parity error is not also reported), and go to BREAK.
- BREAK: stay until `sdin`=1, then go to IDLE. This prevents a held-low line from being taken as a new start bit.
- Output handshake: `dout_valid` clears on the cycle after acceptance, unless a new word loads on that same edge.
- Reset values: state IDLE, `cnt`=0, shift register 0, `dout`=0, `dout_valid`=0, and `frame_err`, `parity_err`, `overrun` all 0.
- Reset mid-frame: the partial frame is discarded with no error pulse. An unread `dout` word is lost.

## Timing
- Start bit sampled at edge 0. Data bit i sampled at edge 1+i. Parity bit, if enabled, sampled at edge WIDTH+1. Stop bit sampled at edge WIDTH+1+P, where P is 1 with parity and 0 without.
- `dout_valid` and `dout` update on the stop-bit edge, so they are visible in the cycle after the stop bit. Latency from stop bit to valid: 1 cycle.
- Error pulses assert in that same cycle and last exactly 1 cycle.
- Back-to-back frames: a start bit placed immediately after a stop bit is detected, giving zero idle gap. Sustained throughput is one word per WIDTH+2+P cycles.
- Simultaneous frame completion and `dout_ready`=1 with `dout_valid`=1: the old word is consumed, the new word loads, `dout_valid` stays 1, and there is no overrun.

## Configuration
- `SERIAL_FRAME_RX_PARITY_EN` defined: the PARITY state exists, and one even-parity bit is expected between the data bits and the stop bit.
- Not defined: there is no PARITY state, the frame is WIDTH+2 bits, and `parity_err` is a constant 0. The port list is identical in both builds.

## Structure
- Package `serial_frame_pkg`:
  - state enum `rx_state_t` (IDLE, DATA, PARITY, STOP, BREAK)
  - constants `LINE_IDLE`=1'b1, `START_BIT`=1'b0, `STOP_BIT`=1'b1
- Sub-module `sipo_shift_reg`: WIDTH-bit serial-in parallel-out register with shift enable and synchronous active-high clear, shifting toward the LSB (right shift) so that the first-received bit ends at bit 0. The top level holds the FSM, bit counter, parity accumulator and output register.

## Test plan
All scenarios use WIDTH=8.
- Basic frame: `sdin` = 0,1,0,1,0,0,1,0,1,1 (start, 0xA5 LSB-first, stop) with `dout_ready`=0 → `dout`=0xA5 and `dout_valid`=1 from the cycle after the stop bit. No error pulses.
- Back-to-back: frame 0x3C immediately followed by frame 0xC3, with `dout_ready`=1 constantly → two words in order, each `dout_valid` for 1 cycle, 10 cycles apart.
- Overrun: two good frames 0x11 then 0x22 with `dout_ready`=0 → `dout` stays 0x11 and `overrun` pulses once at the second stop bit. Raising `dout_ready` then drains 0x11 and `dout_valid` falls.
- Framing error and break: 0x55 with stop bit 0, then `sdin` held at 0 for 5 cycles, then 1 → one `frame_err` pulse, no `dout_valid`, no false start during the low period. The next good frame 0x0F is received correctly.
- Reset mid-frame: assert `reset` for 1 cycle after 4 data bits → state IDLE, `dout_valid`=0, no error pulses. The following frame 0x81 is received correctly.
- Parity (only with `SERIAL_FRAME_RX_PARITY_EN`): 0x07 with parity bit 0 (wrong; expected 1) → `parity_err` pulses and no word is delivered. The same frame with parity bit 1 delivers `dout`=0x07.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receive path.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out register; shifts right so the first bit received lands in bit 0.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_shift_en,
  input  logic             i_din,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_shift_en) begin
      r_q <= {i_din, r_q[WIDTH-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Idle-high one-bit-per-clock frame receiver with a single-entry valid/ready output.
// Optional even parity bit enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdin,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic [WIDTH-1:0] w_shift;
  logic             w_start;
  logic             w_shift_en;

  assign w_start    = (r_state == IDLE) && (sdin == START_BIT);
  assign w_shift_en = (r_state == DATA);

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk        (clk),
    .i_clr      (reset | w_start),
    .i_shift_en (w_shift_en),
    .i_din      (sdin),
    .o_q        (w_shift)
  );

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic r_par;
  logic r_par_bad;
  logic r_parity_err;
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_par        <= 1'b0;
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // A load in STOP below overrides this drain on the same edge.
      if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_cnt <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_par     <= 1'b0;
            r_par_bad <= 1'b0;
`endif
            r_state <= DATA;
          end
        end

        DATA: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          r_par <= r_par ^ sdin;
`endif
          if (r_cnt == CNT_LAST) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            r_state <= PARITY;
`else
            r_state <= STOP;
`endif
          end
        end

`ifdef SERIAL_FRAME_RX_PARITY_EN
        PARITY: begin
          r_par_bad <= (sdin != r_par);
          r_state   <= STOP;
        end
`endif

        STOP: begin
          if (sdin == STOP_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            if (r_par_bad) r_parity_err <= 1'b1;
            else
`endif
            if (!r_dout_valid || dout_ready) begin
              r_dout       <= w_shift;
              r_dout_valid <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
            r_state <= IDLE;
          end else begin
            r_frame_err <= 1'b1;
            r_state     <= BREAK;
          end
        end

        // Wait for the line to return high so a held-low line is not a new start.
        BREAK: begin
          if (sdin == LINE_IDLE) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx: the line stream is built frame by frame, and
// expected outputs follow from what each built frame is known to contain.
module tb_serial_frame_rx;

  localparam int WIDTH = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int EV_NONE = 0;
  localparam int EV_GOOD = 1;
  localparam int EV_FERR = 2;
  localparam int EV_PERR = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             sdin;
  logic             dout_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;

  always #5 clk = ~clk;

  serial_frame_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdin       (sdin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Per-cycle stimulus and the frame outcome known to complete on that cycle's edge.
  bit               sd_q[$];
  bit               rdy_q[$];
  bit               rst_q[$];
  int               ev_q[$];
  logic [WIDTH-1:0] evd_q[$];

  int n_total = 0;
  int n_bad   = 0;
  int cur_cyc = -1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
    end
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) return bit'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic push(input bit s, input int rmode, input bit r, input int ev, input logic [WIDTH-1:0] d);
    sd_q.push_back(s);
    rdy_q.push_back(pick_rdy(rmode));
    rst_q.push_back(r);
    ev_q.push_back(ev);
    evd_q.push_back(d);
  endtask

  task automatic add_line(input bit level, input int n, input int rmode);
    for (int i = 0; i < n; i++) push(level, rmode, 1'b0, EV_NONE, '0);
  endtask

  task automatic add_frame(input logic [WIDTH-1:0] d, input bit good_stop, input bit par_ok, input int rmode);
    int ev;
    push(1'b0, rmode, 1'b0, EV_NONE, '0);
    for (int i = 0; i < WIDTH; i++) push(d[i], rmode, 1'b0, EV_NONE, '0);
    if (P == 1) push((^d) ^ ~par_ok, rmode, 1'b0, EV_NONE, '0);
    if (!good_stop)  ev = EV_FERR;
    else if (!par_ok) ev = EV_PERR;
    else             ev = EV_GOOD;
    push(good_stop, rmode, 1'b0, ev, d);
  endtask

  task automatic add_reset_midframe(input logic [WIDTH-1:0] d, input int nbits);
    push(1'b0, 0, 1'b0, EV_NONE, '0);
    for (int i = 0; i < nbits; i++) push(d[i], 0, 1'b0, EV_NONE, '0);
    push(1'b1, 0, 1'b1, EV_NONE, '0);
  endtask

  initial begin
    bit               mv;
    bit               was_v;
    logic [WIDTH-1:0] md;
    bit               exp_fe, exp_pe, exp_ov;
    bit               good, pok;

    reset = 1'b1; sdin = 1'b1; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_parity_err", parity_err, 0);
    check_val("rst_overrun", overrun, 0);

    // Basic frame held unread, then drained.
    add_frame(8'hA5, 1'b1, 1'b1, 0);
    add_line(1'b1, 2, 0);
    add_line(1'b1, 2, 1);
    // Back-to-back with consumer always ready.
    add_frame(8'h3C, 1'b1, 1'b1, 1);
    add_frame(8'hC3, 1'b1, 1'b1, 1);
    add_line(1'b1, 2, 1);
    // Overrun, then drain.
    add_frame(8'h11, 1'b1, 1'b1, 0);
    add_frame(8'h22, 1'b1, 1'b1, 0);
    add_line(1'b1, 2, 0);
    add_line(1'b1, 2, 1);
    // Framing error, held-low break, recovery.
    add_frame(8'h55, 1'b0, 1'b1, 1);
    add_line(1'b0, 5, 1);
    add_line(1'b1, 1, 1);
    add_frame(8'h0F, 1'b1, 1'b1, 1);
    add_line(1'b1, 2, 1);
    // Unread word plus a partial frame, both wiped by reset.
    add_frame(8'h99, 1'b1, 1'b1, 0);
    add_reset_midframe(8'h81, 4);
    add_frame(8'h81, 1'b1, 1'b1, 0);
    add_line(1'b1, 2, 1);
    if (P == 1) begin
      add_frame(8'h07, 1'b1, 1'b0, 1);
      add_frame(8'h07, 1'b1, 1'b1, 1);
      add_line(1'b1, 2, 1);
    end
    // Random traffic with random consumer back-pressure.
    for (int f = 0; f < 300; f++) begin
      good = ($urandom_range(0, 7) != 0);
      pok  = (P == 0) || ($urandom_range(0, 7) != 0);
      add_frame(WIDTH'($urandom), good, pok, 2);
      if (good) begin
        add_line(1'b1, $urandom_range(0, 2), 2);
      end else begin
        add_line(1'b0, $urandom_range(0, 4), 2);
        add_line(1'b1, $urandom_range(1, 2), 2);
      end
    end
    add_line(1'b1, 3, 1);

    mv = 1'b0;
    md = '0;
    for (int k = 0; k < sd_q.size(); k++) begin
      @(negedge clk);
      sdin       = sd_q[k];
      dout_ready = rdy_q[k];
      reset      = rst_q[k];
      @(posedge clk);
      #1;
      cur_cyc = k;
      exp_fe = 1'b0; exp_pe = 1'b0; exp_ov = 1'b0;
      if (rst_q[k]) begin
        mv = 1'b0;
        md = '0;
      end else begin
        was_v = mv;
        if (mv && rdy_q[k]) mv = 1'b0;
        case (ev_q[k])
          EV_GOOD: begin
            if (!was_v || rdy_q[k]) begin
              md = evd_q[k];
              mv = 1'b1;
            end else begin
              exp_ov = 1'b1;
            end
          end
          EV_FERR: exp_fe = 1'b1;
          EV_PERR: exp_pe = 1'b1;
          default: ;
        endcase
      end
      check_val("dout_valid", dout_valid, mv);
      if (mv || rst_q[k]) check_val("dout", dout, md);
      check_val("frame_err", frame_err, exp_fe);
      check_val("parity_err", parity_err, exp_pe);
      check_val("overrun", overrun, exp_ov);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
